// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding,
// byte-order constants of the host frame and word-count limits.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DAT_LO = 3'd3,
        ST_DAT_HI = 3'd4,
        ST_CHK    = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    // Frame fields are little-endian: low byte first, then high byte.
    localparam int BYTE_W  = 8;
    localparam int LO_BYTE = 0;
    localparam int HI_BYTE = 1;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int MAX_WORDS      = 2 ** DEFAULT_ADDR_W;

    // Largest legal word count for a given address width (one full memory).
    function automatic logic [16:0] max_words(input int addr_w);
        return 17'(1) << addr_w;
    endfunction

    // Place two frame bytes into a 16-bit field using the frame byte order.
    function automatic logic [15:0] join_bytes(input logic [BYTE_W-1:0] hi,
                                               input logic [BYTE_W-1:0] lo);
        logic [15:0] w;
        w = '0;
        w[LO_BYTE*BYTE_W +: BYTE_W] = lo;
        w[HI_BYTE*BYTE_W +: BYTE_W] = hi;
        return w;
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Datapath helper for the loader: low-byte latch, word index counter and the
// running XOR over every accepted frame byte.
module loader_word_assembler
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc,
    input  logic              lo_we,
    input  logic              word_inc,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [BYTE_W-1:0] lo_byte,
    output logic [ADDR_W:0]   word_idx,
    output logic [BYTE_W-1:0] xor_sum
);

    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

    logic [BYTE_W-1:0] lo_q;
    logic [ADDR_W:0]   idx_q;
    logic [BYTE_W-1:0] xor_q;

    // Hold the first byte of a little-endian pair until its partner arrives.
    always_ff @(posedge clk) begin
        if (lo_we) begin
            lo_q <= byte_data;
        end
    end

    // Word index (one extra bit so a full memory does not wrap) and checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            xor_q <= '0;
        end else if (clr) begin
            idx_q <= '0;
            xor_q <= '0;
        end else begin
            if (acc) begin
                xor_q <= xor_q ^ byte_data;
            end
            if (word_inc) begin
                idx_q <= idx_q + IDX_ONE;
            end
        end
    end

    assign lo_byte  = lo_q;
    assign word_idx = idx_q;
    assign xor_sum  = xor_q;

endmodule

// File: rtl/program_loader.sv
// Boot-time instruction loader: parses a checksummed byte frame from the host,
// writes 16-bit words into instruction memory from address 0 and releases the
// processor from reset only once the image has been verified.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int W      = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [W-1:0]      imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);
    localparam logic [16:0]     MAXW    = max_words(ADDR_W);

    state_e            state_q;
    logic [ADDR_W:0]   n_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [W-1:0]      wdata_q;
    logic              hold_q, busy_q, done_q, err_q;

    logic              acc, clr, lo_we, word_inc;
    logic [7:0]        lo_byte, xor_sum;
    logic [ADDR_W:0]   word_idx;
    logic [15:0]       field;

    // Ready purely from state so the host sees a stable handshake.
    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            ST_CNT_LO, ST_CNT_HI, ST_DAT_LO, ST_DAT_HI, ST_CHK: byte_ready = 1'b1;
            default:                                            byte_ready = 1'b0;
        endcase
    end

    assign acc      = byte_valid && byte_ready;
    assign clr      = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign lo_we    = acc && (state_q == ST_CNT_LO || state_q == ST_DAT_LO);
    assign word_inc = acc && (state_q == ST_DAT_HI);
    assign field    = join_bytes(byte_data, lo_byte);

    loader_word_assembler #(.ADDR_W(ADDR_W)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .acc       (acc),
        .lo_we     (lo_we),
        .word_inc  (word_inc),
        .byte_data (byte_data),
        .lo_byte   (lo_byte),
        .word_idx  (word_idx),
        .xor_sum   (xor_sum)
    );

    // Frame-parsing FSM with all status and memory-port outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q <= ST_CNT_LO;
                        hold_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                ST_CNT_LO: begin
                    if (acc) state_q <= ST_CNT_HI;
                end
                ST_CNT_HI: begin
                    if (acc) begin
                        if ({1'b0, field} > MAXW) begin
                            state_q <= ST_ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else if (field == 16'd0) begin
                            state_q <= ST_CHK;
                        end else begin
                            state_q <= ST_DAT_LO;
                            n_q     <= field[ADDR_W:0];
                        end
                    end
                end
                ST_DAT_LO: begin
                    if (acc) state_q <= ST_DAT_HI;
                end
                ST_DAT_HI: begin
                    if (acc) begin
                        we_q    <= 1'b1;
                        addr_q  <= word_idx[ADDR_W-1:0];
                        wdata_q <= field;
                        state_q <= (word_idx + IDX_ONE == n_q) ? ST_CHK : ST_DAT_LO;
                    end
                end
                ST_CHK: begin
                    if (acc) begin
                        busy_q <= 1'b0;
                        if (byte_data == xor_sum) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
